// File: rtl/frame_config_sequencer.sv
// Column config sequencer: loads one frame of row words into FrameData,
// then pulses a single FrameStrobe bit to latch it into the column.
module frame_config_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  UserCLK,
  input  logic                                  Reset,
  input  logic [FrameBitsPerRow-1:0]            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_addr,
  output logic [15:0]                           frame_count
);

  localparam int NS = NumColumns * MaxFramesPerCol;
  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row_q;
  logic [3:0]    scnt_q;
  logic [7:0]    col_q;
  logic [7:0]    frm_q;
  logic          xfer;
  logic          hdr;
  logic          hdr_ok;
  logic          last_row;
  logic          strobe_end;
  logic [16:0]   sidx;

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid & in_ready;
  assign hdr      = (in_data[31:24] == 8'hA5);
  // 9-bit compares keep a 256-entry limit representable
  assign hdr_ok   = ({1'b0, in_data[15:8]} < 9'(NumColumns)) &&
                    ({1'b0, in_data[7:0]} < 9'(MaxFramesPerCol));
  assign last_row   = (row_q == RW'(NumRows - 1));
  assign strobe_end = (scnt_q == 4'(StrobeCycles - 1));
  assign sidx = 17'(col_q) * 17'(MaxFramesPerCol) + 17'(frm_q);

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer && hdr && hdr_ok) state_nxt = LOAD;
      LOAD:    if (xfer && last_row) state_nxt = STROBE;
      STROBE:  if (strobe_end) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      FrameData   <= '0;
      FrameStrobe <= '0;
      row_q       <= '0;
      scnt_q      <= '0;
      col_q       <= '0;
      frm_q       <= '0;
      done        <= 1'b0;
      err_addr    <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= (state == STROBE) && strobe_end;
      if (state == HOLD) frame_count <= frame_count + 16'd1;
      if (state == IDLE && xfer && hdr && !hdr_ok) err_addr <= 1'b1;
      else if (err_clr)                            err_addr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && hdr && hdr_ok) begin
            col_q <= in_data[15:8];
            frm_q <= in_data[7:0];
            row_q <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            FrameData[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
            row_q <= row_q + RW'(1);
            if (last_row) begin
              scnt_q <= '0;
              for (int i = 0; i < NS; i++)
                FrameStrobe[i] <= (17'(i) == sidx);
            end
          end
        end
        STROBE: begin
          if (strobe_end) FrameStrobe <= '0;
          else            scnt_q <= scnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: framing, errors, stalls,
// async reset mid-strobe and frame counter wrap.
module tb_frame_config_sequencer;

  logic         UserCLK = 1'b0;
  logic         Reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         err_clr;
  logic [127:0] FrameData;
  logic [79:0]  FrameStrobe;
  logic         busy;
  logic         done;
  logic         err_addr;
  logic [15:0]  frame_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 UserCLK = ~UserCLK;

  frame_config_sequencer dut (
    .UserCLK     (UserCLK),
    .Reset       (Reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .err_clr     (err_clr),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .done        (done),
    .err_addr    (err_addr),
    .frame_count (frame_count)
  );

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [79:0] bit_at(input int idx);
    logic [79:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl got rdy=%b busy=%b done=%b want 1 0 0",
               in_ready, busy, done);
    end
    n_cmp++;
    if (FrameData !== '0 || FrameStrobe !== '0) begin
      n_err++;
      $display("FAIL reset_data got fd=%h fs=%h want 0", FrameData, FrameStrobe);
    end
    n_cmp++;
    if (err_addr !== 1'b0 || frame_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt got err=%b cnt=%h want 0 0", err_addr, frame_count);
    end
  endtask

  task automatic test_basic_frame();
    int low;
    send(32'hA500_0103);
    send(32'h1111_1111);
    send(32'h2222_2222);
    send(32'h3333_3333);
    send(32'h4444_4444);
    low = 0;
    n_cmp++;
    if (FrameStrobe !== bit_at(23)) begin
      n_err++;
      $display("FAIL basic_strobe1 got %h want %h", FrameStrobe, bit_at(23));
    end
    if (!in_ready) low++;
    tick();
    n_cmp++;
    if (FrameStrobe !== bit_at(23)) begin
      n_err++;
      $display("FAIL basic_strobe2 got %h want %h", FrameStrobe, bit_at(23));
    end
    if (!in_ready) low++;
    tick();
    n_cmp++;
    if (FrameStrobe !== '0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL basic_hold got fs=%h done=%b want 0 1", FrameStrobe, done);
    end
    n_cmp++;
    if (FrameData !== 128'h44444444_33333333_22222222_11111111) begin
      n_err++;
      $display("FAIL basic_data got %h want 44..33..22..11", FrameData);
    end
    if (!in_ready) low++;
    tick();
    if (!in_ready) low++;
    n_cmp++;
    if (low !== 3) begin
      n_err++;
      $display("FAIL basic_ready_low got %0d want 3", low);
    end
    n_cmp++;
    if (frame_count !== 16'd1 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end got cnt=%h done=%b busy=%b want 1 0 0",
               frame_count, done, busy);
    end
  endtask

  task automatic test_addr_error();
    send(32'hA500_0414);
    n_cmp++;
    if (err_addr !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL err_set got err=%b rdy=%b busy=%b want 1 1 0",
               err_addr, in_ready, busy);
    end
    n_cmp++;
    if (FrameStrobe !== '0) begin
      n_err++;
      $display("FAIL err_nostrobe got %h want 0", FrameStrobe);
    end
    err_clr = 1'b1;
    send(32'hA500_0000);
    err_clr = 1'b0;
    n_cmp++;
    if (err_addr !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL err_clr got err=%b busy=%b want 0 1", err_addr, busy);
    end
    send(32'h0000_00A0);
    send(32'h0000_00A1);
    send(32'h0000_00A2);
    send(32'h0000_00A3);
    n_cmp++;
    if (FrameStrobe !== bit_at(0)) begin
      n_err++;
      $display("FAIL err_frame_strobe got %h want %h", FrameStrobe, bit_at(0));
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (frame_count !== 16'd2) begin
      n_err++;
      $display("FAIL err_frame_cnt got %h want 2", frame_count);
    end
  endtask

  task automatic test_garbage();
    send(32'h1234_5678);
    send(32'hDEAD_BEEF);
    n_cmp++;
    if (err_addr !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL garbage_idle got err=%b busy=%b want 0 0", err_addr, busy);
    end
    send(32'hA500_0200);
    send(32'hA5A5_A5A5);
    send(32'h0BAD_0001);
    send(32'h0BAD_0002);
    send(32'h0BAD_0003);
    n_cmp++;
    if (FrameStrobe !== bit_at(40)) begin
      n_err++;
      $display("FAIL garbage_strobe got %h want %h", FrameStrobe, bit_at(40));
    end
    n_cmp++;
    if (FrameData !== 128'h0BAD0003_0BAD0002_0BAD0001_A5A5A5A5) begin
      n_err++;
      $display("FAIL garbage_data got %h want 0bad0003..a5a5a5a5", FrameData);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_stall();
    int bad;
    send(32'hA500_0313);
    send(32'hCAFE_0000);
    send(32'hCAFE_0001);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b1 || in_ready !== 1'b1 || FrameStrobe !== '0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    send(32'hCAFE_0002);
    n_cmp++;
    if (FrameStrobe !== '0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_row2 got fs=%h busy=%b want 0 1", FrameStrobe, busy);
    end
    send(32'hCAFE_0003);
    n_cmp++;
    if (FrameStrobe !== bit_at(79)) begin
      n_err++;
      $display("FAIL stall_strobe got %h want %h", FrameStrobe, bit_at(79));
    end
    n_cmp++;
    if (FrameData !== 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000) begin
      n_err++;
      $display("FAIL stall_data got %h want cafe0003..cafe0000", FrameData);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (frame_count !== 16'd4) begin
      n_err++;
      $display("FAIL stall_cnt got %h want 4", frame_count);
    end
  endtask

  task automatic test_reset_mid_strobe();
    send(32'hA500_0305);
    send(32'h5555_0000);
    send(32'h5555_0001);
    send(32'h5555_0002);
    send(32'h5555_0003);
    tick();
    n_cmp++;
    if (FrameStrobe !== bit_at(65)) begin
      n_err++;
      $display("FAIL rst_pre got %h want %h", FrameStrobe, bit_at(65));
    end
    #1;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (FrameStrobe !== '0 || FrameData !== '0) begin
      n_err++;
      $display("FAIL rst_async got fs=%h fd=%h want 0", FrameStrobe, FrameData);
    end
    n_cmp++;
    if (busy !== 1'b0 || frame_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_state got busy=%b cnt=%h want 0 0", busy, frame_count);
    end
    @(negedge UserCLK);
    Reset = 1'b0;
    tick();
    send(32'hA500_0101);
    send(32'h7777_0000);
    send(32'h7777_0001);
    send(32'h7777_0002);
    send(32'h7777_0003);
    n_cmp++;
    if (FrameStrobe !== bit_at(21)) begin
      n_err++;
      $display("FAIL rst_after_strobe got %h want %h", FrameStrobe, bit_at(21));
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (frame_count !== 16'd1 || FrameData !== 128'h77770003_77770002_77770001_77770000) begin
      n_err++;
      $display("FAIL rst_after_end got cnt=%h fd=%h want 1 7777..", frame_count, FrameData);
    end
  endtask

  task automatic test_count_wrap();
    int dones;
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    tick();
    n_cmp++;
    if (frame_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload got %h want ffff", frame_count);
    end
    send(32'hA500_0002);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0003);
    send(32'h0000_0004);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL wrap_done got %0d pulses want 1", dones);
    end
    n_cmp++;
    if (frame_count !== 16'h0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_cnt got cnt=%h busy=%b want 0 0", frame_count, busy);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    #12;
    test_reset();
    @(negedge UserCLK);
    Reset = 1'b0;
    tick();
    test_basic_frame();
    test_addr_error();
    test_garbage();
    test_stall();
    test_reset_mid_strobe();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
